snowbro2_pcm_arb: RTL

SNOWBRO2_PCM_ARB -- requirements
Module: snowbro2_pcm_arb

---
 rtl/snowbro2_pcm_arb.sv | 105 ++++++++++
 1 files changed

// File: rtl/snowbro2_pcm_arb.sv
// snowbro2_pcm_arb: round-robin arbiter sharing one PCM ROM port between two ADPCM requesters
// Optional fetch timeout with sticky ERR: define SNOWBRO2_PCMARB_TIMEOUT_EN
module snowbro2_pcm_arb (
    input  logic        CLK96,
    input  logic        RESET96,
    input  logic [17:0] OKI0_ADDR,
    input  logic [17:0] OKI1_ADDR,
    input  logic [1:0]  OKI0_BANK,
    input  logic [1:0]  OKI1_BANK,
    output logic [7:0]  OKI0_DATA,
    output logic [7:0]  OKI1_DATA,
    output logic        OKI0_OK,
    output logic        OKI1_OK,
    output logic        PCM_CS,
    output logic [19:0] PCM_ADDR,
    input  logic [7:0]  PCM_DOUT,
    input  logic        PCM_OK,
    output logic        ERR
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT} state_t;
    state_t      r_state, w_next;
    logic [19:0] w_key0, w_key1, r_sk0, r_sk1, r_issue;
    logic        r_v0, r_v1, r_ptr, r_gnt;
    logic        w_pend0, w_pend1, w_gnt, w_start, w_done, w_tmo;
    logic [7:0]  w_data;

    assign w_key0   = {OKI0_BANK, OKI0_ADDR};
    assign w_key1   = {OKI1_BANK, OKI1_ADDR};
    assign OKI0_OK  = r_v0 && (w_key0 == r_sk0);
    assign OKI1_OK  = r_v1 && (w_key1 == r_sk1);
    assign w_pend0  = !OKI0_OK;
    assign w_pend1  = !OKI1_OK;
    assign w_gnt    = (w_pend0 && w_pend1) ? r_ptr : w_pend1;
    assign w_start  = (r_state == S_IDLE) && (w_pend0 || w_pend1);
    assign w_done   = (r_state == S_WAIT) && (PCM_OK || w_tmo);
    assign w_data   = PCM_OK ? PCM_DOUT : 8'h00;
    assign PCM_CS   = r_state != S_IDLE;
    assign PCM_ADDR = r_issue;

`ifdef SNOWBRO2_PCMARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;
    assign w_tmo = (r_cnt == 8'hFF) && !PCM_OK;
    assign ERR   = r_err;
    // Count WAIT cycles from zero for each fetch; a give-up completion latches ERR
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == S_IDLE) ? 8'h00 : (r_state == S_WAIT) ? r_cnt + 8'h01 : r_cnt;
            if (w_done && w_tmo) r_err <= 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
    assign ERR   = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK96) begin
        if (RESET96) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // Next state: grant from IDLE, one stale-data cycle in SETTLE, hold in WAIT until done
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE) w_next = w_start ? S_SETTLE : S_IDLE;
        else if (r_state == S_SETTLE) w_next = S_WAIT;
        else w_next = w_done ? S_IDLE : S_WAIT;
    end

    // Latch the granted key on issue; on completion store data and served key for the grantee
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            r_issue   <= '0;
            r_gnt     <= 1'b0;
            r_ptr     <= 1'b0;
            r_sk0     <= '0;
            r_sk1     <= '0;
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            OKI0_DATA <= '0;
            OKI1_DATA <= '0;
        end else begin
            if (w_start) begin
                r_issue <= w_gnt ? w_key1 : w_key0;
                r_gnt   <= w_gnt;
            end
            if (w_done) begin
                r_ptr <= !r_ptr;
                if (r_gnt) begin
                    OKI1_DATA <= w_data;
                    r_sk1     <= r_issue;
                    r_v1      <= 1'b1;
                end else begin
                    OKI0_DATA <= w_data;
                    r_sk0     <= r_issue;
                    r_v0      <= 1'b1;
                end
            end
        end
    end
endmodule
